// File: rtl/lut_compress_writer_if.sv
// Coordinate-stream input and LUT BRAM write-port bundle for the compressed LUT writer.
// master = host/loader side, slave = lut_compress_writer.
interface lut_compress_writer_if #(
    parameter int ADDR_W = 13
);
    logic              frame_start;
    logic              coord_valid;
    logic [15:0]       coord_x;
    logic [15:0]       coord_y;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr;
    logic [63:0]       bram_wdata;
    logic              frame_done;
    logic              lut_ready;
    logic              err_short;

    modport master (
        output frame_start, coord_valid, coord_x, coord_y,
        input  bram_we, bram_waddr, bram_wdata, frame_done, lut_ready, err_short
    );

    modport slave (
        input  frame_start, coord_valid, coord_x, coord_y,
        output bram_we, bram_waddr, bram_wdata, frame_done, lut_ready, err_short
    );
endinterface

// File: rtl/lut_compress_writer.sv
// Decimates a raster remap-coordinate stream 8x8 and packs sample pairs into 64-bit
// LUT BRAM words in the layout the LUT decompressor reads back.
module lut_compress_writer #(
    parameter int ORIGINAL_WIDTH    = 1280,
    parameter int ORIGINAL_HEIGHT   = 720,
    parameter int COMPRESSED_WIDTH  = 80,
    parameter int COMPRESSED_HEIGHT = 90,
    parameter int ADDR_W            = 13
) (
    input logic                  clk,
    input logic                  rst,
    lut_compress_writer_if.slave bus
);
    localparam int COL_W = $clog2(ORIGINAL_WIDTH);
    localparam int ROW_W = $clog2(ORIGINAL_HEIGHT);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ORIGINAL_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ORIGINAL_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COMPRESSED_WIDTH * COMPRESSED_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  word_addr;
    logic [31:0]        hold_xy;

    logic accept;
    logic on_grid;
    logic last_pixel;

    always_comb begin
        accept     = (state == CAPTURE) && bus.coord_valid && !bus.frame_start;
        on_grid    = (col[2:0] == 3'd0) && (row[2:0] == 3'd0);
        last_pixel = (col == COL_LAST) && (row == ROW_LAST);
    end

    // Grid words are emitted strictly in address order, so the write address is a
    // plain running count of words rather than g*COMPRESSED_WIDTH + s/2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            word_addr      <= '0;
            hold_xy        <= '0;
            bus.bram_we    <= 1'b0;
            bus.bram_waddr <= '0;
            bus.bram_wdata <= '0;
            bus.frame_done <= 1'b0;
            bus.lut_ready  <= 1'b0;
            bus.err_short  <= 1'b0;
        end else begin
            bus.bram_we    <= 1'b0;
            bus.frame_done <= 1'b0;

            if (bus.frame_done) begin
                bus.lut_ready <= 1'b1;
            end

            if (bus.frame_start) begin
                if (state == CAPTURE) begin
                    bus.err_short <= 1'b1;
                end
                state         <= CAPTURE;
                col           <= '0;
                row           <= '0;
                word_addr     <= '0;
                bus.lut_ready <= 1'b0;
            end else if (accept) begin
                if (on_grid) begin
                    if (!col[3]) begin
                        hold_xy <= {bus.coord_x, bus.coord_y};
                    end else begin
                        bus.bram_we    <= 1'b1;
                        bus.bram_waddr <= word_addr;
                        bus.bram_wdata <= {bus.coord_x, bus.coord_y, hold_xy};
                        bus.frame_done <= (word_addr == ADDR_LAST);
                        word_addr      <= word_addr + ADDR_W'(1);
                    end
                end

                if (last_pixel) begin
                    state <= DONE;
                    col   <= '0;
                    row   <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lut_compress_writer.sv
// Directed bench for lut_compress_writer on a reduced 128x48 raster (8x6 words), with
// coord_x=col and coord_y=row so every packed word has a closed-form expected value.
module tb_lut_compress_writer;
    localparam int OW     = 128;
    localparam int OH     = 48;
    localparam int CWD    = 8;
    localparam int CHT    = 6;
    localparam int AW     = 13;
    localparam int NWORDS = CWD * CHT;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lut_compress_writer_if #(.ADDR_W(AW)) bus ();

    lut_compress_writer #(
        .ORIGINAL_WIDTH   (OW),
        .ORIGINAL_HEIGHT  (OH),
        .COMPRESSED_WIDTH (CWD),
        .COMPRESSED_HEIGHT(CHT),
        .ADDR_W           (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          errors     = 0;
    int          checks     = 0;
    int          wr_count   = 0;
    int          done_count = 0;
    int          exp_addr   = 0;
    bit          wr_enable  = 1'b0;
    bit          prev_done  = 1'b0;
    logic [63:0] mem [NWORDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word a holds grid row g=a/CWD, odd sample at col 16w+8, even sample at col 16w.
    function automatic logic [63:0] exp_word(input int a);
        int g;
        int w;
        g = a / CWD;
        w = a % CWD;
        return {16'(16 * w + 8), 16'(8 * g), 16'(16 * w), 16'(8 * g)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (prev_done) check("lut_ready_after_done", 64'(bus.lut_ready), 64'(1));
            if (bus.bram_we || bus.frame_done) begin
                if (!wr_enable) begin
                    check("write_while_disabled", 64'(bus.bram_we | bus.frame_done), 64'(0));
                end else begin
                    check("waddr", 64'(bus.bram_waddr), 64'(exp_addr));
                    check("wdata", bus.bram_wdata, exp_word(exp_addr));
                    check("frame_done_on_last", 64'(bus.frame_done),
                          64'(bus.bram_we && (exp_addr == NWORDS - 1)));
                    if (bus.bram_we) begin
                        if (int'(bus.bram_waddr) < NWORDS) mem[bus.bram_waddr] <= bus.bram_wdata;
                        exp_addr <= exp_addr + 1;
                    end
                end
                if (bus.bram_we)    wr_count   <= wr_count + 1;
                if (bus.frame_done) done_count <= done_count + 1;
            end
            prev_done <= bus.frame_done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.frame_start = 1'b1;
        exp_addr        = 0;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_pixels(input int rows, input int gap_pct);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < OW; c++) begin
                while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    bus.coord_valid = 1'b0;
                    step();
                end
                bus.coord_valid = 1'b1;
                bus.coord_x     = 16'(c);
                bus.coord_y     = 16'(r);
                step();
            end
        end
        bus.coord_valid = 1'b0;
    endtask

    task automatic check_full_frame(input string tag, input logic exp_err);
        step();
        step();
        check({tag, "_writes"}, 64'(wr_count), 64'(NWORDS));
        check({tag, "_done_pulses"}, 64'(done_count), 64'(1));
        check({tag, "_lut_ready"}, 64'(bus.lut_ready), 64'(1));
        check({tag, "_err_short"}, 64'(bus.err_short), 64'(exp_err));
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.coord_valid = 1'b0;
        bus.coord_x     = '0;
        bus.coord_y     = '0;
        repeat (3) step();

        check("rst_bram_we",    64'(bus.bram_we),    64'(0));
        check("rst_bram_waddr", 64'(bus.bram_waddr), 64'(0));
        check("rst_bram_wdata", bus.bram_wdata,      64'(0));
        check("rst_frame_done", 64'(bus.frame_done), 64'(0));
        check("rst_lut_ready",  64'(bus.lut_ready),  64'(0));
        check("rst_err_short",  64'(bus.err_short),  64'(0));
        rst = 1'b0;
        step();

        // IDLE ignores coord_valid
        send_pixels(9, 0);
        step();
        check("idle_no_writes", 64'(wr_count), 64'(0));
        check("idle_lut_ready", 64'(bus.lut_ready), 64'(0));

        // Full frame, continuous valid
        wr_enable = 1'b1;
        pulse_start();
        check("f1_lut_ready_low", 64'(bus.lut_ready), 64'(0));
        send_pixels(OH, 0);
        check_full_frame("f1", 1'b0);
        check("word_0",    mem[0],  64'h0008_0000_0000_0000);
        check("word_1",    mem[1],  {16'd24, 16'd0, 16'd16, 16'd0});
        check("word_row1", mem[8],  {16'd8, 16'd8, 16'd0, 16'd8});
        check("word_last", mem[47], {16'd120, 16'd40, 16'd112, 16'd40});

        // DONE ignores coord_valid
        wr_enable = 1'b0;
        send_pixels(2, 0);
        step();
        check("done_no_writes", 64'(wr_count), 64'(NWORDS));
        check("done_lut_ready", 64'(bus.lut_ready), 64'(1));

        // frame_start from DONE, gapped valid stream
        wr_enable  = 1'b1;
        wr_count   = 0;
        done_count = 0;
        pulse_start();
        check("f2_ready_cleared", 64'(bus.lut_ready), 64'(0));
        send_pixels(OH, 40);
        check_full_frame("f2_gapped", 1'b0);

        // Short frame: restart after half the lines
        wr_count   = 0;
        done_count = 0;
        pulse_start();
        send_pixels(24, 0);
        step();
        check("short_partial_writes", 64'(wr_count), 64'(24));
        wr_count = 0;
        pulse_start();
        check("short_err_short", 64'(bus.err_short), 64'(1));
        check("short_lut_ready", 64'(bus.lut_ready), 64'(0));
        send_pixels(OH, 0);
        check_full_frame("f3_after_short", 1'b1);

        // Asynchronous reset mid-frame
        wr_count   = 0;
        done_count = 0;
        pulse_start();
        send_pixels(12, 0);
        step();
        check("pre_rst_writes", 64'(wr_count), 64'(16));
        check("pre_rst_waddr",  64'(bus.bram_waddr), 64'(15));
        check("pre_rst_wdata",  bus.bram_wdata, exp_word(15));
        #2;
        rst = 1'b1;
        #1;
        check("arst_bram_we",    64'(bus.bram_we),    64'(0));
        check("arst_bram_waddr", 64'(bus.bram_waddr), 64'(0));
        check("arst_bram_wdata", bus.bram_wdata,      64'(0));
        check("arst_frame_done", 64'(bus.frame_done), 64'(0));
        check("arst_lut_ready",  64'(bus.lut_ready),  64'(0));
        check("arst_err_short",  64'(bus.err_short),  64'(0));
        step();
        rst      = 1'b0;
        wr_count = 0;
        step();
        pulse_start();
        send_pixels(9, 0);
        step();
        check("post_rst_writes",    64'(wr_count), 64'(16));
        check("post_rst_waddr",     64'(bus.bram_waddr), 64'(15));
        check("post_rst_err_short", 64'(bus.err_short), 64'(0));
        check("post_rst_lut_ready", 64'(bus.lut_ready), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_compress_writer.md
Name: lut_compress_writer

Overview:
- Builds the compressed distortion LUT that the LUT decompressor reads back.
- Accepts a full-resolution remap coordinate stream (one X/Y pair per output pixel, raster order) from the calibration/host loader.
- Keeps every 8th column of every 8th row, packs two adjacent grid samples per 64-bit word, and writes the words into the LUT BRAM write port in the exact layout the decompressor expects.
- Signals when a complete table is resident.

Parameters:
- ORIGINAL_WIDTH, 1280, full-resolution pixels per line.
- ORIGINAL_HEIGHT, 720, full-resolution lines per frame.
- COMPRESSED_WIDTH, 80, BRAM words per grid row (= ORIGINAL_WIDTH/16, two samples per word).
- COMPRESSED_HEIGHT, 90, grid rows (= ORIGINAL_HEIGHT/8).
- ADDR_W, 13, BRAM address width.

Ports:
- clk  in  1  pixel clock, 74.25 MHz
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  single-cycle pulse; arms capture of a new table
- coord_valid  in  1  coord_x/coord_y valid this cycle
- coord_x  in  16  source X for current pixel
- coord_y  in  16  source Y for current pixel
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_W  BRAM write address
- bram_wdata  out  64  packed word
- frame_done  out  1  single-cycle pulse, last word written
- lut_ready  out  1  complete table in BRAM
- err_short  out  1  sticky; frame_start arrived before the table was complete

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - bram_we=0, bram_waddr=0, bram_wdata=0.
  - frame_done=0, lut_ready=0, err_short=0.
  - State is IDLE; all counters are 0.
- State machine:
  - IDLE → CAPTURE on frame_start.
  - CAPTURE → DONE after the pixel at col=ORIGINAL_WIDTH-1, row=ORIGINAL_HEIGHT-1 is accepted.
  - DONE → CAPTURE on frame_start.
  - CAPTURE → CAPTURE on frame_start: set err_short, clear all counters, restart the table.
  - coord_valid is ignored in IDLE and DONE.
- Pixel counters: col 0..ORIGINAL_WIDTH-1, row 0..ORIGINAL_HEIGHT-1.
  - Advance only on coord_valid in CAPTURE; col wraps to 0 and increments row.
  - Gaps in coord_valid are allowed and have no effect.
- Sampling condition: col[2:0]==0 and row[2:0]==0. Sample index s=col>>3 (0..159); grid row g=row>>3 (0..89).
- Even s: latch {coord_x, coord_y} into the low holding register. No write.
- Odd s: on the next cycle assert bram_we for exactly 1 cycle, with:
  - bram_waddr = g*COMPRESSED_WIDTH + (s>>1), range 0..7199. Computed incrementally (running word address); no multiplier.
  - bram_wdata[63:48]=odd X, [47:32]=odd Y, [31:16]=held even X, [15:0]=held even Y.
- Write latency: 1 cycle from the accepting edge of the odd sample. bram_waddr/bram_wdata are held stable while bram_we=1 and hold their last value otherwise.
- Word count: exactly COMPRESSED_WIDTH*COMPRESSED_HEIGHT = 7200 writes per table, with strictly increasing addresses.
- Completion:
  - frame_done pulses in the same cycle as the final write (address 7199).
  - lut_ready rises the cycle after frame_done.
  - lut_ready stays 1 until the next frame_start, which clears it on the following edge.
  - Downstream must not issue LUT requests while lut_ready=0.
- Simultaneous events:
  - frame_start together with coord_valid: frame_start wins; that pixel is discarded.
  - A pending odd-sample write still completes in the cycle after frame_start.
- err_short is cleared only by rst.
- Reset mid-frame: all outputs return to reset values immediately. Partial BRAM contents are not invalidated; lut_ready=0 marks them unusable.
- Coordinate values pass through unmodified. No rounding, no clamping, no fixed-point conversion.

Test Plan:
- Full frame, coord_x=col, coord_y=row, continuous valid:
  - addr 0 = 0x0008_0000_0000_0000.
  - addr 1 = {24,0,16,0}.
  - addr 80 = {8,8,0,8}.
  - addr 7199 = {1272,712,1264,712}.
  - Exactly 7200 writes; frame_done coincides with addr 7199; lut_ready=1 one cycle later.
- Same frame with coord_valid deasserted pseudo-randomly (~40%) → identical write sequence and data, stretched in time.
- frame_start after 300 lines → err_short=1; restart; the next full frame produces 7200 writes starting at addr 0.
- coord_valid pulses while in IDLE and DONE → no writes; lut_ready unchanged.
- rst asserted at row 100 → all outputs 0 asynchronously; after release plus frame_start, capture restarts at addr 0.
- frame_start while in DONE → lut_ready drops next edge; the second table overwrites from addr 0 with no err_short.
